// File: rtl/riscv_defines_pkg.sv
// Shared RISC-V datapath definitions: operand width, ALU opcodes and the issue-stage state encoding.
package riscv_defines_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned RD_WIDTH   = 5;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLT,
      ALU_SLTU
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } alu_iss_state_t;

   // Operation captured at the input handshake and replayed towards the ALU.
   typedef struct packed {
      alu_op_t               op;
      logic [DATA_WIDTH-1:0] src1;
      logic [DATA_WIDTH-1:0] src2;
      logic [RD_WIDTH-1:0]   rd;
   } alu_iss_req_t;

endpackage

// File: rtl/alu_if.sv
// Request/response channel between an issue stage (master) and an ALU (slave).
interface alu_if;
   import riscv_defines_pkg::*;

   logic [DATA_WIDTH-1:0] operand1;
   logic [DATA_WIDTH-1:0] operand2;
   alu_op_t               alu_op;
   logic                  req_valid;
   logic [DATA_WIDTH-1:0] result;
   logic                  resp_valid;
   logic                  resp_ready;

   modport master (
      output operand1, operand2, alu_op, req_valid,
      input  result, resp_valid, resp_ready
   );

   modport slave (
      input  operand1, operand2, alu_op, req_valid,
      output result, resp_valid, resp_ready
   );

endinterface

// File: rtl/alu_issuer.sv
// ALU issue stage: accepts one operation, issues it over alu_if and hands the result downstream.
// Optional WAIT-state timeout is compiled in with ALU_ISSUE_TIMEOUT_EN.
module alu_issuer
   import riscv_defines_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  alu_op_t               in_op,
   input  logic [DATA_WIDTH-1:0] in_src1,
   input  logic [DATA_WIDTH-1:0] in_src2,
   input  logic [RD_WIDTH-1:0]   in_rd,
   alu_if.master                 alu_if,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [RD_WIDTH-1:0]   out_rd,
   output logic                  err_timeout
);

   alu_iss_state_t        state_q, state_d;
   alu_iss_req_t          req_q, req_d;
   logic [DATA_WIDTH-1:0] out_result_q, out_result_d;
   logic [RD_WIDTH-1:0]   out_rd_q, out_rd_d;
   logic                  req_valid_q;
   logic                  out_valid_q;
   logic                  accept_c;
   logic                  timeout_c;

   // DONE can take a new operation in the same cycle its result leaves.
   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept_c = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      out_result_d = out_result_q;
      out_rd_d     = out_rd_q;

      if (accept_c) begin
         req_d = '{op: in_op, src1: in_src1, src2: in_src2, rd: in_rd};
      end

      unique case (state_q)
         IDLE: begin
            if (accept_c) state_d = REQ;
         end
         REQ: begin
            if (req_valid_q && alu_if.resp_ready) state_d = WAIT;
         end
         WAIT: begin
            if (timeout_c) begin
               out_result_d = '0;
               out_rd_d     = req_q.rd;
               state_d      = DONE;
            end else if (alu_if.resp_valid) begin
               out_result_d = alu_if.result;
               out_rd_d     = req_q.rd;
               state_d      = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = accept_c ? REQ : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         req_q        <= '0;
         out_result_q <= '0;
         out_rd_q     <= '0;
         req_valid_q  <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         out_result_q <= out_result_d;
         out_rd_q     <= out_rd_d;
         req_valid_q  <= (state_d == REQ);
         out_valid_q  <= (state_d == DONE);
      end
   end

`ifdef ALU_ISSUE_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Counter sits at zero outside WAIT; the pulse fires at the end of the last allowed WAIT cycle.
   always_comb begin
      cnt_d = '0;
      err_d = 1'b0;
      if (state_q == WAIT) begin
         cnt_d = cnt_q + CNT_W'(1);
         err_d = !alu_if.resp_valid && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign timeout_c   = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
   assign err_timeout = err_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_c          = 1'b0;
   assign err_timeout        = 1'b0;
`endif

   assign alu_if.operand1  = req_q.src1;
   assign alu_if.operand2  = req_q.src2;
   assign alu_if.alu_op    = req_q.op;
   assign alu_if.req_valid = req_valid_q;

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_rd     = out_rd_q;

endmodule
